// File: rtl/nand_pkg.sv
// Shared definitions for the NAND channel command/address path.
// Contents: sequencer state encoding, maximum address byte count,
// common ONFI command opcodes and an address-count clamp helper.
package nand_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WE_LO = 3'd2,
        WE_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         MAX_ADDR_BYTES = 5;

    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] CMD_READ1 = 8'h00;
    localparam logic [7:0] CMD_READ2 = 8'h30;

    // Requests asking for more address bytes than the bus carries are
    // limited to the full five-byte row+column address.
    function automatic logic [2:0] clamp_naddr(input logic [2:0] n);
        return (n > 3'(MAX_ADDR_BYTES)) ? 3'(MAX_ADDR_BYTES) : n;
    endfunction

endpackage

// File: rtl/nand_byte_mux.sv
// Byte selector for one command packet.
// Maps a byte index onto the packet layout: cmd1 (CLE), then the address
// bytes LSB first (ALE), then the optional confirm command (CLE).
// Ports:
//   i_idx      byte index within the packet (0 = cmd1)
//   i_naddr    number of address bytes, already clamped to 0..5
//   i_cmd1     first command byte
//   i_addr     address bytes, byte 0 in bits [7:0]
//   i_cmd2_en  confirm command present
//   i_cmd2     confirm command byte
//   o_byte     byte to place on DQ
//   o_cle      byte is a command cycle
//   o_ale      byte is an address cycle
module nand_byte_mux
    import nand_pkg::*;
(
    input  logic [2:0]  i_idx,
    input  logic [2:0]  i_naddr,
    input  logic [7:0]  i_cmd1,
    input  logic [39:0] i_addr,
    input  logic        i_cmd2_en,
    input  logic [7:0]  i_cmd2,
    output logic [7:0]  o_byte,
    output logic        o_cle,
    output logic        o_ale
);

    logic [2:0] w_aidx;

    always_comb begin
        w_aidx = i_idx - 3'd1;
        o_byte = 8'h00;
        o_cle  = 1'b0;
        o_ale  = 1'b0;
        if (i_idx == 3'd0) begin
            o_byte = i_cmd1;
            o_cle  = 1'b1;
        end else if (i_idx <= i_naddr) begin
            o_ale = 1'b1;
            case (w_aidx)
                3'd0:    o_byte = i_addr[7:0];
                3'd1:    o_byte = i_addr[15:8];
                3'd2:    o_byte = i_addr[23:16];
                3'd3:    o_byte = i_addr[31:24];
                3'd4:    o_byte = i_addr[39:32];
                default: o_byte = 8'h00;
            endcase
        end else if (i_cmd2_en) begin
            o_byte = i_cmd2;
            o_cle  = 1'b1;
        end
    end

endmodule

// File: rtl/nand_cmd_seq.sv
// Asynchronous-mode (SDR) command/address sequencer for one NAND channel.
// Accepts a command packet (cmd1, 0..5 address bytes, optional cmd2, chip
// index) and writes it to the flash through nand_phy, one byte per
// SETUP / WE_LO / WE_HI phase group with programmable widths.
// Ports:
//   clk0, rst0            clock, synchronous active-high reset
//   req_*                 request handshake and packet fields
//   done, busy            completion pulse and activity flag
//   ctrl_cle/ale/wen      NAND control pins (WE# level on ctrl_wen)
//   ctrl_wen_sel          WE# mode select, always async mode
//   ctrl_cen              active-low chip enables
//   dq_oe_n               DQ output enable, active-low
//   wr_data_rise/fall     byte driven on DQ (same byte on both)
module nand_cmd_seq
    import nand_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_WP    = 3,
    parameter int T_WH    = 2
) (
    input  logic        clk0,
    input  logic        rst0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd1,
    input  logic [2:0]  req_naddr,
    input  logic [39:0] req_addr,
    input  logic        req_cmd2_en,
    input  logic [7:0]  req_cmd2,
    input  logic [2:0]  req_ce,
    output logic        done,
    output logic        busy,
    output logic        ctrl_cle,
    output logic        ctrl_ale,
    output logic        ctrl_wen,
    output logic        ctrl_wen_sel,
    output logic [7:0]  ctrl_cen,
    output logic        dq_oe_n,
    output logic [7:0]  wr_data_rise,
    output logic [7:0]  wr_data_fall
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;

    logic [7:0]  r_cmd1;
    logic [2:0]  r_naddr;
    logic [39:0] r_addr;
    logic        r_cmd2_en;
    logic [7:0]  r_cmd2;
    logic [2:0]  r_ce;

    logic        w_accept;
    logic [2:0]  w_last;
    logic        w_active;

    // Packet as it will be after this edge: on the accept cycle the request
    // inputs are used directly so the first SETUP byte is registered in time.
    logic [7:0]  w_p_cmd1;
    logic [2:0]  w_p_naddr;
    logic [39:0] w_p_addr;
    logic        w_p_cmd2_en;
    logic [7:0]  w_p_cmd2;
    logic [2:0]  w_p_ce;

    logic [7:0]  w_byte;
    logic        w_cle;
    logic        w_ale;

    assign req_ready = (r_state == IDLE) & ~rst0;
    assign w_accept  = req_valid & req_ready;
    assign w_last    = r_naddr + {2'b00, r_cmd2_en};

    assign w_p_cmd1    = w_accept ? req_cmd1               : r_cmd1;
    assign w_p_naddr   = w_accept ? clamp_naddr(req_naddr) : r_naddr;
    assign w_p_addr    = w_accept ? req_addr               : r_addr;
    assign w_p_cmd2_en = w_accept ? req_cmd2_en            : r_cmd2_en;
    assign w_p_cmd2    = w_accept ? req_cmd2               : r_cmd2;
    assign w_p_ce      = w_accept ? req_ce                 : r_ce;

    nand_byte_mux u_byte_mux (
        .i_idx     (w_idx_nxt),
        .i_naddr   (w_p_naddr),
        .i_cmd1    (w_p_cmd1),
        .i_addr    (w_p_addr),
        .i_cmd2_en (w_p_cmd2_en),
        .i_cmd2    (w_p_cmd2),
        .o_byte    (w_byte),
        .o_cle     (w_cle),
        .o_ale     (w_ale)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 4'd1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_idx_nxt   = 3'd0;
                end
            end
            SETUP: if (r_cnt == 4'(T_SETUP - 1)) w_state_nxt = WE_LO;
            WE_LO: if (r_cnt == 4'(T_WP - 1))    w_state_nxt = WE_HI;
            WE_HI: begin
                if (r_cnt == 4'(T_WH - 1)) begin
                    if (r_idx == w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = SETUP;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Every state change (including WE_HI -> SETUP) restarts the phase count.
        if (w_state_nxt != r_state) w_cnt_nxt = 4'd0;
    end

    assign w_active = (w_state_nxt == SETUP) || (w_state_nxt == WE_LO) ||
                      (w_state_nxt == WE_HI);

    always_ff @(posedge clk0) begin
        if (w_accept) begin
            r_cmd1    <= req_cmd1;
            r_naddr   <= clamp_naddr(req_naddr);
            r_addr    <= req_addr;
            r_cmd2_en <= req_cmd2_en;
            r_cmd2    <= req_cmd2;
            r_ce      <= req_ce;
        end
    end

    // Outputs are registered from the next state so pin changes line up
    // exactly with state entry.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= 3'd0;
            ctrl_cle     <= 1'b0;
            ctrl_ale     <= 1'b0;
            ctrl_wen     <= 1'b1;
            ctrl_wen_sel <= 1'b1;
            ctrl_cen     <= 8'hFF;
            dq_oe_n      <= 1'b1;
            wr_data_rise <= 8'h00;
            wr_data_fall <= 8'h00;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            ctrl_cle     <= w_active & w_cle;
            ctrl_ale     <= w_active & w_ale;
            ctrl_wen     <= (w_state_nxt != WE_LO);
            ctrl_wen_sel <= 1'b1;
            ctrl_cen     <= w_active ? ~(8'h01 << w_p_ce) : 8'hFF;
            dq_oe_n      <= ~w_active;
            if (w_active) begin
                wr_data_rise <= w_byte;
                wr_data_fall <= w_byte;
            end
            done         <= (w_state_nxt == DONE);
            busy         <= (w_state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_nand_cmd_seq.sv
module tb_nand_cmd_seq;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        req_valid;
    logic        sel;
    logic [7:0]  req_cmd1;
    logic [2:0]  req_naddr;
    logic [39:0] req_addr;
    logic        req_cmd2_en;
    logic [7:0]  req_cmd2;
    logic [2:0]  req_ce;

    logic        a_valid, b_valid;
    assign a_valid = req_valid & ~sel;
    assign b_valid = req_valid & sel;

    logic       a_ready, a_done, a_busy, a_cle, a_ale, a_wen, a_wsel, a_oe_n;
    logic [7:0] a_cen, a_rise, a_fall;
    logic       b_ready, b_done, b_busy, b_cle, b_ale, b_wen, b_wsel, b_oe_n;
    logic [7:0] b_cen, b_rise, b_fall;

    nand_cmd_seq u_dut_a (
        .clk0(clk0), .rst0(rst0), .req_valid(a_valid), .req_ready(a_ready),
        .req_cmd1(req_cmd1), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_cmd2_en(req_cmd2_en), .req_cmd2(req_cmd2), .req_ce(req_ce),
        .done(a_done), .busy(a_busy), .ctrl_cle(a_cle), .ctrl_ale(a_ale),
        .ctrl_wen(a_wen), .ctrl_wen_sel(a_wsel), .ctrl_cen(a_cen),
        .dq_oe_n(a_oe_n), .wr_data_rise(a_rise), .wr_data_fall(a_fall)
    );

    nand_cmd_seq #(.T_SETUP(1), .T_WP(1), .T_WH(1)) u_dut_b (
        .clk0(clk0), .rst0(rst0), .req_valid(b_valid), .req_ready(b_ready),
        .req_cmd1(req_cmd1), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_cmd2_en(req_cmd2_en), .req_cmd2(req_cmd2), .req_ce(req_ce),
        .done(b_done), .busy(b_busy), .ctrl_cle(b_cle), .ctrl_ale(b_ale),
        .ctrl_wen(b_wen), .ctrl_wen_sel(b_wsel), .ctrl_cen(b_cen),
        .dq_oe_n(b_oe_n), .wr_data_rise(b_rise), .wr_data_fall(b_fall)
    );

    logic       o_ready, o_done, o_busy, o_cle, o_ale, o_wen, o_wsel, o_oe_n;
    logic [7:0] o_cen, o_rise, o_fall;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_done  = sel ? b_done  : a_done;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_cle   = sel ? b_cle   : a_cle;
    assign o_ale   = sel ? b_ale   : a_ale;
    assign o_wen   = sel ? b_wen   : a_wen;
    assign o_wsel  = sel ? b_wsel  : a_wsel;
    assign o_oe_n  = sel ? b_oe_n  : a_oe_n;
    assign o_cen   = sel ? b_cen   : a_cen;
    assign o_rise  = sel ? b_rise  : a_rise;
    assign o_fall  = sel ? b_fall  : a_fall;

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic       cle;
        logic       ale;
        logic [7:0] d;
        logic [7:0] cen;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Second packet of the back-to-back test, presented while packet 1 runs.
    logic [7:0]  p2_cmd1  = 8'h80;
    logic [2:0]  p2_naddr = 3'd2;
    logic [39:0] p2_addr  = 40'h00_0000_CDEF;
    logic        p2_c2en  = 1'b1;
    logic [7:0]  p2_cmd2  = 8'h10;
    logic [2:0]  p2_ce    = 3'd3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] c1, input logic [2:0] na, input logic [39:0] ad,
                            input logic c2en, input logic [7:0] c2, input logic [2:0] ce);
        int n;
        logic [7:0] m;
        exp_t e;
        m = 8'h01 << ce;
        n = (na > 3'd5) ? 5 : int'(na);
        e = '{cle: 1'b1, ale: 1'b0, d: c1, cen: ~m};
        q.push_back(e);
        for (int k = 0; k < n; k++) begin
            e = '{cle: 1'b0, ale: 1'b1, d: ad[8*k +: 8], cen: ~m};
            q.push_back(e);
        end
        if (c2en) begin
            e = '{cle: 1'b1, ale: 1'b0, d: c2, cen: ~m};
            q.push_back(e);
        end
    endtask

    task automatic start_pkt(input logic [7:0] c1, input logic [2:0] na, input logic [39:0] ad,
                             input logic c2en, input logic [7:0] c2, input logic [2:0] ce,
                             input bit expect_bytes);
        chk("ready_before_req", {63'd0, o_ready}, 64'd1);
        if (expect_bytes) push_exp(c1, na, ad, c2en, c2, ce);
        req_cmd1 = c1; req_naddr = na; req_addr = ad;
        req_cmd2_en = c2en; req_cmd2 = c2; req_ce = ce;
        req_valid = 1'b1;
    endtask

    // Observes outputs every cycle after an accept; every WE# fall pops one
    // expected byte. Cycle numbers are relative to the accept cycle.
    task automatic watch(input int n_done, input bit b2b, output int d0, output int d1,
                         output int lo_first, output int lo_cnt, output int ale_cnt,
                         output bit glitch);
        logic p_wen, p_cle, p_ale;
        logic [7:0] p_d;
        exp_t e;
        int nd;
        nd = 0; d0 = -1; d1 = -1; lo_first = -1; lo_cnt = 0; ale_cnt = 0; glitch = 1'b0;
        p_wen = 1'b1; p_cle = 1'b0; p_ale = 1'b0; p_d = 8'h00;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk0);
            if (k == 1 && !b2b) req_valid = 1'b0;
            if (k == 1 && b2b) begin
                req_cmd1 = p2_cmd1; req_naddr = p2_naddr; req_addr = p2_addr;
                req_cmd2_en = p2_c2en; req_cmd2 = p2_cmd2; req_ce = p2_ce;
            end
            if (b2b && nd == 1 && k == d0 + 2) req_valid = 1'b0;
            if (k == 1) chk("busy_first_setup", {63'd0, o_busy}, 64'd1);
            if (o_done) begin
                chk("ready_low_in_done", {63'd0, o_ready}, 64'd0);
                if (nd == 0) d0 = k; else d1 = k;
                nd++;
            end
            if (!o_wen) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = k;
            end
            if (p_wen && !o_wen) begin
                if (o_cle !== p_cle || o_ale !== p_ale || o_rise !== p_d) glitch = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_byte", {56'd0, o_rise}, 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("byte_flags_data", {54'd0, o_cle, o_ale, o_rise},
                        {54'd0, e.cle, e.ale, e.d});
                    chk("byte_cen", {56'd0, o_cen}, {56'd0, e.cen});
                    chk("rise_eq_fall", {56'd0, o_fall}, {56'd0, o_rise});
                end
                if (o_ale) ale_cnt++;
            end
            if (o_cle && o_ale) glitch = 1'b1;
            p_wen = o_wen; p_cle = o_cle; p_ale = o_ale; p_d = o_rise;
            if (nd == n_done) break;
        end
    endtask

    initial begin
        int d0, d1, lo_first, lo_cnt, ale_cnt, ndone;
        bit glitch;
        sel = 1'b0; rst0 = 1'b1; req_valid = 1'b0;
        req_cmd1 = 8'h00; req_naddr = 3'd0; req_addr = 40'd0;
        req_cmd2_en = 1'b0; req_cmd2 = 8'h00; req_ce = 3'd0;

        // Reset state
        repeat (3) @(negedge clk0);
        chk("ready_in_reset", {63'd0, o_ready}, 64'd0);
        rst0 = 1'b0;
        @(negedge clk0);
        chk("reset_ctrl", {56'd0, o_cle, o_ale, o_wen, o_wsel, o_oe_n, o_done, o_busy, o_ready},
            {56'd0, 8'b0011_1001});
        chk("reset_cen", {56'd0, o_cen}, 64'hFF);
        chk("reset_data", {48'd0, o_rise, o_fall}, 64'h0000);

        // Reset command: single CLE byte, default timing
        start_pkt(8'hFF, 3'd0, 40'd0, 1'b0, 8'h00, 3'd0, 1'b1);
        @(negedge clk0);
        chk("rstcmd_n1", {46'd0, o_cle, o_ale, o_rise, o_cen}, {46'd0, 2'b10, 8'hFF, 8'hFE});
        // one cycle already consumed: watcher offsets shift by one
        req_valid = 1'b0;
        q.delete();
        push_exp(8'hFF, 3'd0, 40'd0, 1'b0, 8'h00, 3'd0);
        watch(1, 1'b1, d0, d1, lo_first, lo_cnt, ale_cnt, glitch);
        chk("rstcmd_done", d0 + 1, 8);
        chk("rstcmd_we_first", lo_first + 1, 3);
        chk("rstcmd_we_len", lo_cnt, 3);
        chk("rstcmd_glitch", {63'd0, glitch}, 64'd0);
        @(negedge clk0);

        // Page read, ce=5
        start_pkt(8'h00, 3'd5, 40'h04_0302_0100, 1'b1, 8'h30, 3'd5, 1'b1);
        watch(1, 1'b0, d0, d1, lo_first, lo_cnt, ale_cnt, glitch);
        chk("read_done", d0, 50);
        chk("read_ale_cnt", ale_cnt, 5);
        chk("read_glitch", {63'd0, glitch}, 64'd0);
        chk("read_queue_empty", q.size(), 0);
        chk("read_post_done", {56'd0, o_cen}, 64'hFF);
        @(negedge clk0);

        // Address count clamp
        start_pkt(8'h60, 3'd7, 40'hA5_B4C3_D2E1, 1'b1, 8'hD0, 3'd7, 1'b1);
        watch(1, 1'b0, d0, d1, lo_first, lo_cnt, ale_cnt, glitch);
        chk("clamp_done", d0, 50);
        chk("clamp_ale_cnt", ale_cnt, 5);
        chk("clamp_queue_empty", q.size(), 0);
        @(negedge clk0);

        // Reset during WE_LO of byte 2
        start_pkt(8'h00, 3'd3, 40'h00_0077_6655, 1'b0, 8'h00, 3'd1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk0);
            if (k == 1) req_valid = 1'b0;
        end
        chk("midrst_in_we_lo", {63'd0, o_wen}, 64'd0);
        rst0 = 1'b1;
        @(negedge clk0);
        chk("midrst_ctrl", {60'd0, o_wen, o_oe_n, o_cle, o_ale}, {60'd0, 4'b1100});
        chk("midrst_cen", {56'd0, o_cen}, 64'hFF);
        chk("midrst_done_busy", {62'd0, o_done, o_busy}, 64'd0);
        rst0 = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, o_ready}, 64'd1);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk0);
            if (o_done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // Back-to-back with req_valid held high
        start_pkt(8'h70, 3'd1, 40'h00_0000_00AB, 1'b0, 8'h00, 3'd2, 1'b1);
        push_exp(p2_cmd1, p2_naddr, p2_addr, p2_c2en, p2_cmd2, p2_ce);
        watch(2, 1'b1, d0, d1, lo_first, lo_cnt, ale_cnt, glitch);
        chk("b2b_done1", d0, 15);
        chk("b2b_done2_gap", d1 - d0, 30);
        chk("b2b_queue_empty", q.size(), 0);
        chk("b2b_glitch", {63'd0, glitch}, 64'd0);
        @(negedge clk0);

        // Minimum timing instance
        sel = 1'b1;
        #1;
        start_pkt(8'hFF, 3'd0, 40'd0, 1'b0, 8'h00, 3'd4, 1'b1);
        watch(1, 1'b0, d0, d1, lo_first, lo_cnt, ale_cnt, glitch);
        chk("fast_done", d0, 4);
        chk("fast_we_first", lo_first, 2);
        chk("fast_we_len", lo_cnt, 1);
        chk("fast_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
